// File: rtl/serial_tx_unit_pkg.sv
// Shared types and defaults for the serial transmit path of the IO unit.
// Holds the byte datapath type, the transmitter FSM state enum and the line-level helper.
package IO_UnitTypes;

    typedef logic [7:0] SerialDataPath;

    localparam int SERIAL_TX_CLK_DIV    = 16;
    localparam int SERIAL_TX_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } SerialTxState;

    // Level the UART line should carry while the FSM sits in a given state.
    function automatic logic serial_tx_line_level(input SerialTxState st,
                                                  input SerialDataPath shift);
        logic level;
        case (st)
            START:   level = 1'b0;
            DATA:    level = shift[0];
            default: level = 1'b1;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/serial_tx_unit_fifo.sv
// Circular byte FIFO feeding the serial transmitter.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module serial_tx_fifo
    import IO_UnitTypes::*;
#(
    parameter int DEPTH = SERIAL_TX_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  SerialDataPath          push_data,
    output SerialDataPath          pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    SerialDataPath mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/serial_tx_unit.sv
// 8N1 UART transmitter with a byte FIFO, baud divider and sticky overflow flag.
// The line level is registered from the current FSM state, so txd trails the state by one clock.
module serial_tx_unit
    import IO_UnitTypes::*;
#(
    parameter int CLK_DIV    = SERIAL_TX_CLK_DIV,
    parameter int FIFO_DEPTH = SERIAL_TX_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        serialWE,
    input  SerialDataPath               serialWriteData,
    input  logic                        overflowClear,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount,
    output logic                        overflow
);

    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    SerialTxState  state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    SerialDataPath shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;

    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    SerialDataPath               fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        baud_end;
    logic                        write_drop;

    serial_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (serialWE),
        .pop       (fifo_pop),
        .push_data (serialWriteData),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        baud_end  = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_head;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d    = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        txd_d      = serial_tx_line_level(state_q, shift_q);
        // Registered alongside txd so busy drops only after the stop bit has left the pin.
        busy_d     = (state_q != IDLE) || !fifo_empty;
        write_drop = serialWE && fifo_full && !fifo_pop;
        overflow_d = overflow_q;
        if (write_drop) begin
            overflow_d = 1'b1;
        end else if (overflowClear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd       = txd_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign fifoCount = fifo_count;

endmodule

// File: tb/tb_serial_tx_unit.sv
// Scoreboarded bench for serial_tx_unit: a frame-timing reference model predicts the pins
// each cycle, and a UART receiver model checks every decoded byte against the expected queue.
module tb_serial_tx_unit;

    localparam int DIV   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * DIV;
    localparam int HALF  = DIV / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serialWE = 1'b0;
    logic [7:0] serialWriteData = 8'h00;
    logic       overflowClear = 1'b0;
    logic       txd;
    logic       busy;
    logic [4:0] fifoCount;
    logic       overflow;

    serial_tx_unit #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .serialWE        (serialWE),
        .serialWriteData (serialWriteData),
        .overflowClear   (overflowClear),
        .txd             (txd),
        .busy            (busy),
        .fifoCount       (fifoCount),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the timing of the frame on the wire.
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    int         m_cyc     = 0;
    int         m_pop_at  = 0;
    int         m_free_at = 0;
    logic       m_have    = 1'b0;
    logic [7:0] m_cur     = 8'h00;
    logic       m_ovf     = 1'b0;
    logic       m_idle;
    logic       m_pop;
    logic       m_acc;
    logic       exp_txd   = 1'b1;
    logic       exp_busy  = 1'b0;
    int         exp_count = 0;

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq.delete();
                sb.delete();
                m_have    = 1'b0;
                m_ovf     = 1'b0;
                exp_txd   = 1'b1;
                exp_busy  = 1'b0;
                exp_count = 0;
            end else begin
                m_cyc++;
                m_idle   = !m_have || (m_cyc > m_free_at);
                m_pop    = m_idle && (mq.size() > 0);
                exp_busy = !m_idle || (mq.size() > 0);
                if (m_have && (m_cyc - 1 - m_pop_at) < FRAME)
                    exp_txd = frame_bit(m_cur, (m_cyc - 1 - m_pop_at) / DIV);
                else
                    exp_txd = 1'b1;
                m_acc = serialWE && ((mq.size() < DEPTH) || m_pop);
                if (m_pop) begin
                    m_cur     = mq.pop_front();
                    m_have    = 1'b1;
                    m_pop_at  = m_cyc;
                    m_free_at = m_cyc + FRAME;
                end
                if (m_acc) begin
                    mq.push_back(serialWriteData);
                    sb.push_back(serialWriteData);
                end
                if (serialWE && !m_acc) m_ovf = 1'b1;
                else if (overflowClear) m_ovf = 1'b0;
                exp_count = mq.size();
            end
        end
    end

    // Per-cycle pin comparison, sampled mid-period.
    int peak_dut = 0;
    initial begin
        forever begin
            @(negedge clk);
            chk("txd", txd, exp_txd);
            chk("fifoCount", fifoCount, exp_count);
            chk("busy", busy, exp_busy);
            chk("overflow", overflow, m_ovf);
            if (int'(fifoCount) > peak_dut) peak_dut = int'(fifoCount);
        end
    end

    // UART receiver: sample bit centres and pop the scoreboard on each stop bit.
    logic       rx_on   = 1'b0;
    int         rx_cnt  = 0;
    int         rx_k;
    logic [7:0] rx_byte = 8'h00;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (txd === 1'b0) begin
                    rx_on  = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % DIV == HALF) begin
                    rx_k = rx_cnt / DIV;
                    if (rx_k == 0) begin
                        chk("rx_start", txd, 1'b0);
                    end else if (rx_k <= 8) begin
                        rx_byte = {txd, rx_byte[7:1]};
                    end else begin
                        chk("rx_stop", txd, 1'b1);
                        if (sb.size() == 0) begin
                            chk("rx_unexpected_byte", 32'(rx_byte) | 32'h100, 32'(rx_byte));
                        end else begin
                            chk("rx_byte", rx_byte, sb.pop_front());
                        end
                        rx_on = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [7:0] d, input logic clr);
        serialWE        = we;
        serialWriteData = d;
        overflowClear   = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || mq.size() != 0 || exp_busy) && n < budget) begin
            drive(1'b0, 8'h00, 1'b0);
            n++;
        end
        n_vec++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL %s: still busy after %0d cycles, expected drained", name, n);
        end
        repeat (3) drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_txd", txd, 1'b1);
        chk("reset_count", fifoCount, 0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b1;

        // Single byte frame.
        peak_dut = 0;
        drive(1'b1, 8'h55, 1'b0);
        wait_drain("drain_single", 200);
        chk("peak_single", peak_dut, 1);

        // Back-to-back writes.
        peak_dut = 0;
        drive(1'b1, 8'hA3, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        wait_drain("drain_three", 400);
        chk("peak_three", peak_dut, 2);

        // Overflow: 18 writes, last one dropped; clear; drop beats clear.
        for (int i = 0; i < 18; i++) drive(1'b1, 8'(i), 1'b0);
        chk("ovf_set", overflow, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("ovf_clear", overflow, 1'b0);
        drive(1'b1, 8'h77, 1'b1);
        chk("ovf_drop_wins", overflow, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        wait_drain("drain_overflow", 2000);

        // Full FIFO with a write landing on the pop edge.
        for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
        n = 0;
        while (!((m_cyc + 1 > m_free_at) && mq.size() == DEPTH) && n < 100) begin
            drive(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("popwrite_wait_ok", n < 100, 1'b1);
        drive(1'b1, 8'hC5, 1'b0);
        chk("popwrite_count", fifoCount, DEPTH);
        chk("popwrite_ovf", overflow, 1'b0);
        wait_drain("drain_popwrite", 2000);

        // Reset in the middle of the data bits.
        drive(1'b1, 8'h3C, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        repeat (8) drive(1'b0, 8'h00, 1'b0);
        chk("pre_rst_txd", txd, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_count", fifoCount, 0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        drive(1'b1, 8'h81, 1'b0);
        chk("post_rst_count", fifoCount, 1);
        wait_drain("drain_after_reset", 200);

        // 40 random bytes at a paced rate.
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 50)) drive(1'b0, 8'h00, 1'b0);
        end
        wait_drain("drain_paced", 4000);

        // Random bursts with random overflow clears.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0));
        end
        drive(1'b0, 8'h00, 1'b0);
        wait_drain("drain_random", 30000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
